pc_fetch_unit: RTL and testbench

- Program counter register and fetch sequencer for the single-cycle MIPS32 core.
- Selects the next PC from four sources and holds the current PC.
  - Sequential: pc+1.
  - Branch: branch adder output.
  - Jump: jump address generator output.
  - JR: register target.
- Drives the word address to instruction memory using a req/ready handshake.
- Also provides pcplus1 back to the jump and branch address units, plus a retired-instruction counter.
- PC is word-addressed: +1 per instruction, no byte offset.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_fetch_unit_next_pc_sel.sv | 35 +++
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the MIPS32 fetch path: FSM states,
// address defaults and the next-PC source encoding.
package cpu_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Priority mux for the next PC: JR over jump over taken branch over pc+1.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pcplus1,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jr,
    output logic [ADDR_W-1:0] next_pc,
    output pc_sel_t           sel
);

    // NOTE: every output gets a default first so no path through the
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        sel     = SEL_SEQ;
        next_pc = pcplus1;
        if (jr) begin
            sel     = SEL_JR;
            next_pc = jr_target;
        end else if (jump) begin
            sel     = SEL_J;
            next_pc = jump_target;
        end else if (branch_taken) begin
            sel     = SEL_BR;
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: holds the PC, handshakes with
// instruction memory and counts retired instructions.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jr,
    input  logic              stall,
    input  logic              halt,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcplus1,
    output logic              advance,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] next_pc;
    pc_sel_t           sel;

    assign pcplus1   = pc + ADDR_W'(1);
    assign imem_addr = pc;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pcplus1      (pcplus1),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .next_pc      (next_pc),
        .sel          (sel)
    );

    // The select code is kept for debug visibility only.
    logic unused_sel;
    assign unused_sel = ^sel;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (advance && halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req = (state == FETCH);
        halted   = (state == HALTED);
        advance  = (state == FETCH) && imem_ready && !stall;
    end

    // A retiring halt still counts but leaves the PC on the halt word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_count <= '0;
        end else if (advance) begin
            instr_count <= instr_count + CNT_W'(1);
            if (!halt) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the steady-state
// fetch behaviour plus hand sequences for boot, halt and async reset.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_target, jump_target, jr_target;
    logic        branch_taken, jump, jr, stall, halt, imem_ready;
    logic        imem_req, advance, halted;
    logic [31:0] imem_addr, pc, pcplus1, instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .stall        (stall),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pcplus1      (pcplus1),
        .advance      (advance),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    typedef struct {
        logic        rdy, stl, hlt, jr_e, j_e, br_e;
        logic [31:0] jr_t, j_t, br_t;
        logic        exp_adv;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic rdy, stl, hlt, jr_e, j_e, br_e,
                                input logic [31:0] jr_t, j_t, br_t,
                                input logic exp_adv,
                                input logic [31:0] exp_pc, exp_cnt);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.hlt = hlt;
        v.jr_e = jr_e; v.j_e = j_e; v.br_e = br_e;
        v.jr_t = jr_t; v.j_t = j_t; v.br_t = br_t;
        v.exp_adv = exp_adv; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        branch_target = '0; jump_target = '0; jr_target = '0;
        branch_taken = 0; jump = 0; jr = 0; stall = 0; halt = 0; imem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        vecs[0]  = mk(1,0,0,0,0,0, 0,0,0, 1, 32'h1, 1);
        vecs[1]  = mk(1,0,0,0,0,0, 0,0,0, 1, 32'h2, 2);
        vecs[2]  = mk(1,0,0,0,0,0, 0,0,0, 1, 32'h3, 3);
        vecs[3]  = mk(1,0,0,0,0,1, 0,0,32'h5, 1, 32'h5, 4);
        vecs[4]  = mk(1,0,0,1,1,1, 32'h100,32'h200,32'h300, 1, 32'h100, 5);
        vecs[5]  = mk(1,0,0,0,1,1, 32'h100,32'h200,32'h300, 1, 32'h200, 6);
        vecs[6]  = mk(0,0,0,0,0,1, 0,0,32'h300, 0, 32'h200, 6);
        vecs[7]  = mk(1,0,0,0,0,1, 0,0,32'h8, 1, 32'h8, 7);
        vecs[8]  = mk(0,0,0,1,0,0, 32'h55,0,0, 0, 32'h8, 7);
        vecs[9]  = mk(0,0,0,1,0,0, 32'h55,0,0, 0, 32'h8, 7);
        vecs[10] = mk(0,0,0,1,0,0, 32'h55,0,0, 0, 32'h8, 7);
        vecs[11] = mk(1,1,0,0,1,0, 0,32'h66,0, 0, 32'h8, 7);
        vecs[12] = mk(1,0,0,0,0,0, 0,0,0, 1, 32'h9, 8);
        vecs[13] = mk(1,0,0,1,0,0, 32'hFFFF_FFFF,0,0, 1, 32'hFFFF_FFFF, 9);
        vecs[14] = mk(1,0,0,0,0,0, 0,0,0, 1, 32'h0, 10);
        vecs[15] = mk(1,0,0,1,0,0, 32'h40,0,0, 1, 32'h40, 11);
        vecs[16] = mk(1,1,1,0,0,0, 0,0,0, 0, 32'h40, 11);
        vecs[17] = mk(1,0,1,0,0,0, 0,0,0, 1, 32'h40, 12);

        // Reset and boot dead cycle
        do_reset();
        check("boot_req", {31'b0, imem_req}, 32'h0);
        check("boot_pc", pc, 32'h0);
        check("boot_cnt", instr_count, 32'h0);
        check("boot_adv", {31'b0, advance}, 32'h0);
        check("boot_halted", {31'b0, halted}, 32'h0);
        step();
        check("fetch_req", {31'b0, imem_req}, 32'h1);
        check("fetch_pc", pc, 32'h0);

        for (int i = 0; i < 18; i++) begin
            imem_ready = vecs[i].rdy; stall = vecs[i].stl; halt = vecs[i].hlt;
            jr = vecs[i].jr_e; jump = vecs[i].j_e; branch_taken = vecs[i].br_e;
            jr_target = vecs[i].jr_t; jump_target = vecs[i].j_t; branch_target = vecs[i].br_t;
            #1;
            check($sformatf("v%0d_adv", i), {31'b0, advance}, {31'b0, vecs[i].exp_adv});
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'h1);
            step();
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
            check($sformatf("v%0d_cnt", i), instr_count, vecs[i].exp_cnt);
            check($sformatf("v%0d_pcp1", i), pcplus1, vecs[i].exp_pc + 32'd1);
        end

        // Halted: controls are ignored, only reset exits
        idle_inputs();
        jr = 1; jr_target = 32'h99;
        #1;
        check("halt_halted", {31'b0, halted}, 32'h1);
        check("halt_req", {31'b0, imem_req}, 32'h0);
        check("halt_adv", {31'b0, advance}, 32'h0);
        step();
        step();
        check("halt_pc", pc, 32'h40);
        check("halt_cnt", instr_count, 32'd12);
        check("halt_still", {31'b0, halted}, 32'h1);

        // Async reset while stalled at 0x40
        idle_inputs();
        do_reset();
        step();
        jr = 1; jr_target = 32'h40;
        step();
        check("rst2_pc", pc, 32'h40);
        check("rst2_cnt", instr_count, 32'h1);
        jr = 0; stall = 1;
        step();
        check("rst2_stall_pc", pc, 32'h40);
        #3;
        rst = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_cnt", instr_count, 32'h0);
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_adv", {31'b0, advance}, 32'h0);
        check("async_halted", {31'b0, halted}, 32'h0);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
